// File: rtl/ga_pkg.sv
// Shared definitions for the gene pool sorter: controller state codes, FSM enum, default sizes.
// Imported by the interface, the radix pass and the top.
package ga_pkg;

    localparam int DEF_GENE_BIT   = 80;
    localparam int DEF_FIT_BIT    = 10;
    localparam int DEF_POPULATION = 24;
    localparam int DEF_BEST_COUNT = 4;
    localparam int DEF_GROW_UP    = 4;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SORT_ONES  = 3'd1;
    localparam logic [2:0] ST_SORT_ZEROS = 3'd2;
    localparam logic [2:0] ST_SORT_COPY  = 3'd3;
    localparam logic [2:0] ST_BREED_MUT  = 3'd4;
    localparam logic [2:0] ST_BREED_RAND = 3'd5;
    localparam logic [2:0] ST_DONE       = 3'd6;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        SORT_ONES  = ST_SORT_ONES,
        SORT_ZEROS = ST_SORT_ZEROS,
        SORT_COPY  = ST_SORT_COPY,
        BREED_MUT  = ST_BREED_MUT,
        BREED_RAND = ST_BREED_RAND,
        DONE       = ST_DONE
    } state_t;

endpackage

// File: rtl/gene_pool_sorter_if.sv
// Host-side bus of the gene pool sorter: slot writes, read port, sort/breed handshakes, mask stream.
// master = host driving the pool, slave = the sorter itself.
interface gene_pool_sorter_if import ga_pkg::*; #(
    parameter int GENE_BIT   = DEF_GENE_BIT,
    parameter int FIT_BIT    = DEF_FIT_BIT,
    parameter int POPULATION = DEF_POPULATION
);
    localparam int IDX_W = $clog2(POPULATION);

    logic                gene_wr_en;
    logic [IDX_W-1:0]    gene_wr_idx;
    logic [GENE_BIT-1:0] gene_wr_data;
    logic                fit_wr_en;
    logic [IDX_W-1:0]    fit_wr_idx;
    logic [FIT_BIT-1:0]  fit_wr_data;
    logic [IDX_W-1:0]    rd_idx;
    logic [GENE_BIT-1:0] rd_gene;
    logic [FIT_BIT-1:0]  rd_fit;
    logic                sort_start;
    logic                sort_busy;
    logic                sort_done;
    logic                breed_start;
    logic                breed_busy;
    logic                breed_done;
    logic                mask_valid;
    logic [GENE_BIT-1:0] mask_data;
    logic                mask_ready;
    logic [GENE_BIT-1:0] rand_gene;
    logic [FIT_BIT-1:0]  best_fit;

    modport master (
        output gene_wr_en, gene_wr_idx, gene_wr_data,
        output fit_wr_en, fit_wr_idx, fit_wr_data,
        output rd_idx, sort_start, breed_start, mask_valid, mask_data, rand_gene,
        input  rd_gene, rd_fit, sort_busy, sort_done, breed_busy, breed_done,
        input  mask_ready, best_fit
    );

    modport slave (
        input  gene_wr_en, gene_wr_idx, gene_wr_data,
        input  fit_wr_en, fit_wr_idx, fit_wr_data,
        input  rd_idx, sort_start, breed_start, mask_valid, mask_data, rand_gene,
        output rd_gene, rd_fit, sort_busy, sort_done, breed_busy, breed_done,
        output mask_ready, best_fit
    );

endinterface

// File: rtl/gene_radix_pass.sv
// One binary radix pass: compacts scanned entries whose current fitness bit matches into scratch.
// Owns the scratch array, its write pointer and the bit under test; no backpressure.
module gene_radix_pass import ga_pkg::*; #(
    parameter int GENE_BIT   = DEF_GENE_BIT,
    parameter int FIT_BIT    = DEF_FIT_BIT,
    parameter int POPULATION = DEF_POPULATION
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                passClear,
    input  logic                appendEn,
    input  logic                wantOne,
    input  logic                copyEn,
    input  logic [GENE_BIT-1:0] inGene,
    input  logic [FIT_BIT-1:0]  inFit,
    output logic                lastBit,
    output logic [GENE_BIT-1:0] scratchGene [POPULATION],
    output logic [FIT_BIT-1:0]  scratchFit  [POPULATION]
);
    localparam int IDX_W = $clog2(POPULATION);
    localparam int BIT_W = (FIT_BIT > 1) ? $clog2(FIT_BIT) : 1;

    logic [IDX_W-1:0] wrPtr;
    logic [BIT_W-1:0] bitSel;
    logic             keyBit;

    assign keyBit  = inFit[bitSel];
    assign lastBit = (bitSel == BIT_W'(FIT_BIT - 1));

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            wrPtr  <= '0;
            bitSel <= '0;
            for (int i = 0; i < POPULATION; i++) begin
                scratchGene[i] <= '0;
                scratchFit[i]  <= '0;
            end
        end else if (passClear) begin
            wrPtr  <= '0;
            bitSel <= '0;
        end else if (copyEn) begin
            wrPtr  <= '0;
            bitSel <= lastBit ? '0 : bitSel + 1'b1;
        end else if (appendEn && (keyBit == wantOne)) begin
            // Ones-scan then zeros-scan fills exactly POPULATION entries per bit.
            scratchGene[wrPtr] <= inGene;
            scratchFit[wrPtr]  <= inFit;
            wrPtr              <= wrPtr + 1'b1;
        end
    end

endmodule

// File: rtl/gene_pool_sorter.sv
// Gene pool: stable descending radix sort by fitness (FIT_BIT*(2*POPULATION+1) cycles), then elite breeding.
// Mutation waits on mask_valid indefinitely; slot writes are accepted only while idle.
module gene_pool_sorter import ga_pkg::*; #(
    parameter int GENE_BIT   = DEF_GENE_BIT,
    parameter int FIT_BIT    = DEF_FIT_BIT,
    parameter int POPULATION = DEF_POPULATION,
    parameter int BEST_COUNT = DEF_BEST_COUNT,
    parameter int GROW_UP    = DEF_GROW_UP
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    gene_pool_sorter_if.slave  bus
);
    localparam int IDX_W   = $clog2(POPULATION);
    localparam int MUT_END = BEST_COUNT * (1 + GROW_UP);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(POPULATION - 1);

    generate
        if (MUT_END > POPULATION || BEST_COUNT < 1 || GROW_UP < 1) begin : gBadConfig
            $error("gene_pool_sorter: BEST_COUNT*(1+GROW_UP) must fit in POPULATION");
        end
    endgenerate

    logic [GENE_BIT-1:0] geneMem [POPULATION];
    logic [FIT_BIT-1:0]  fitMem  [POPULATION];
    logic [GENE_BIT-1:0] scratchGene [POPULATION];
    logic [FIT_BIT-1:0]  scratchFit  [POPULATION];

    state_t           state;
    logic [IDX_W-1:0] scanIdx;
    logic [IDX_W-1:0] eliteIdx;
    logic [IDX_W-1:0] growIdx;
    logic [IDX_W-1:0] destIdx;
    logic             sortBusy, sortDone, breedBusy, breedDone, maskReady;
    logic [GENE_BIT-1:0] rdGene;
    logic [FIT_BIT-1:0]  rdFit, bestFit;

    logic                isIdle, scanEn, copyEn, maskFire, randEn, sortAccept, lastBit;
    logic                geneWe, fitWe;
    logic [IDX_W-1:0]    geneIdx, fitIdx;
    logic [GENE_BIT-1:0] geneDat;
    logic [FIT_BIT-1:0]  fitDat;

    assign isIdle     = (state == IDLE);
    assign scanEn     = (state == SORT_ONES) || (state == SORT_ZEROS);
    assign copyEn     = (state == SORT_COPY);
    assign maskFire   = bus.mask_valid && maskReady;
    assign randEn     = (state == BREED_RAND);
    assign sortAccept = isIdle && bus.sort_start;

    gene_radix_pass #(
        .GENE_BIT   (GENE_BIT),
        .FIT_BIT    (FIT_BIT),
        .POPULATION (POPULATION)
    ) uRadix (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .passClear   (sortAccept),
        .appendEn    (scanEn),
        .wantOne     (state == SORT_ONES),
        .copyEn      (copyEn),
        .inGene      (geneMem[scanIdx]),
        .inFit       (fitMem[scanIdx]),
        .lastBit     (lastBit),
        .scratchGene (scratchGene),
        .scratchFit  (scratchFit)
    );

    // Single write channel per array: host writes in IDLE, breeding writes otherwise.
    always_comb begin
        geneWe  = 1'b0;
        geneIdx = '0;
        geneDat = '0;
        fitWe   = 1'b0;
        fitIdx  = '0;
        fitDat  = '0;
        if (isIdle) begin
            geneWe  = bus.gene_wr_en && (int'(bus.gene_wr_idx) < POPULATION);
            geneIdx = bus.gene_wr_idx;
            geneDat = bus.gene_wr_data;
            fitWe   = bus.fit_wr_en && (int'(bus.fit_wr_idx) < POPULATION);
            fitIdx  = bus.fit_wr_idx;
            fitDat  = bus.fit_wr_data;
        end else if (maskFire) begin
            geneWe  = 1'b1;
            geneIdx = destIdx;
            geneDat = geneMem[eliteIdx] ^ bus.mask_data;
            fitWe   = 1'b1;
            fitIdx  = destIdx;
        end else if (randEn) begin
            geneWe  = 1'b1;
            geneIdx = destIdx;
            geneDat = bus.rand_gene;
            fitWe   = 1'b1;
            fitIdx  = destIdx;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            for (int i = 0; i < POPULATION; i++) begin
                geneMem[i] <= '0;
                fitMem[i]  <= '0;
            end
            rdGene  <= '0;
            rdFit   <= '0;
            bestFit <= '0;
        end else begin
            rdGene <= (int'(bus.rd_idx) < POPULATION) ? geneMem[bus.rd_idx] : '0;
            rdFit  <= (int'(bus.rd_idx) < POPULATION) ? fitMem[bus.rd_idx]  : '0;
            if (copyEn) begin
                for (int i = 0; i < POPULATION; i++) begin
                    geneMem[i] <= scratchGene[i];
                    fitMem[i]  <= scratchFit[i];
                end
                bestFit <= scratchFit[0];
            end else begin
                if (geneWe) geneMem[geneIdx] <= geneDat;
                if (fitWe) begin
                    fitMem[fitIdx] <= fitDat;
                    if (fitIdx == '0) bestFit <= fitDat;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state     <= IDLE;
            scanIdx   <= '0;
            eliteIdx  <= '0;
            growIdx   <= '0;
            destIdx   <= '0;
            sortBusy  <= 1'b0;
            sortDone  <= 1'b0;
            breedBusy <= 1'b0;
            breedDone <= 1'b0;
            maskReady <= 1'b0;
        end else begin
            sortDone  <= 1'b0;
            breedDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sort_start) begin
                        state    <= SORT_ONES;
                        scanIdx  <= '0;
                        sortBusy <= 1'b1;
                    end else if (bus.breed_start) begin
                        state     <= BREED_MUT;
                        eliteIdx  <= '0;
                        growIdx   <= '0;
                        destIdx   <= IDX_W'(BEST_COUNT);
                        breedBusy <= 1'b1;
                        maskReady <= 1'b1;
                    end
                end
                SORT_ONES: begin
                    scanIdx <= scanIdx + 1'b1;
                    if (scanIdx == LAST_SLOT) begin
                        scanIdx <= '0;
                        state   <= SORT_ZEROS;
                    end
                end
                SORT_ZEROS: begin
                    scanIdx <= scanIdx + 1'b1;
                    if (scanIdx == LAST_SLOT) begin
                        scanIdx <= '0;
                        state   <= SORT_COPY;
                    end
                end
                SORT_COPY: begin
                    if (lastBit) begin
                        state    <= DONE;
                        sortBusy <= 1'b0;
                        sortDone <= 1'b1;
                    end else begin
                        state <= SORT_ONES;
                    end
                end
                BREED_MUT: begin
                    if (maskFire) begin
                        destIdx <= destIdx + 1'b1;
                        if (growIdx == IDX_W'(GROW_UP - 1)) begin
                            growIdx  <= '0;
                            eliteIdx <= eliteIdx + 1'b1;
                            if (eliteIdx == IDX_W'(BEST_COUNT - 1)) begin
                                maskReady <= 1'b0;
                                if (MUT_END < POPULATION) begin
                                    state <= BREED_RAND;
                                end else begin
                                    state     <= DONE;
                                    breedBusy <= 1'b0;
                                    breedDone <= 1'b1;
                                end
                            end
                        end else begin
                            growIdx <= growIdx + 1'b1;
                        end
                    end
                end
                BREED_RAND: begin
                    destIdx <= destIdx + 1'b1;
                    if (destIdx == LAST_SLOT) begin
                        state     <= DONE;
                        breedBusy <= 1'b0;
                        breedDone <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_gene    = rdGene;
    assign bus.rd_fit     = rdFit;
    assign bus.best_fit   = bestFit;
    assign bus.sort_busy  = sortBusy;
    assign bus.sort_done  = sortDone;
    assign bus.breed_busy = breedBusy;
    assign bus.breed_done = breedDone;
    assign bus.mask_ready = maskReady;

endmodule
